// File: rtl/frame_pattern_gen_pkg.sv
// frame_pkg: shared types and constants for the frame pattern generator.
//   frame_state_t : raster FSM states (IDLE, ACTIVE, HBLANK, VBLANK)
//   PAT_*         : pattern select codes carried on i_pattern
//   BAR_*         : the eight 24-bit {r,g,b} colour-bar constants, left to right
//   bar_color()   : bar index -> colour
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } frame_state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_pattern_gen_if.sv
// frame_pattern_gen_if: registered pixel stream from the pattern generator
// to the colour processing stage.
//   color_r/g/b      : pixel colour, 0 outside active video
//   valid            : active pixel present this cycle
//   start_frame_flag : one-cycle pulse with pixel (0,0)
//   end_frame_flag   : one-cycle pulse with the last active pixel
// Modports: master (generator side, drives), slave (consumer side).
interface frame_pattern_gen_if;

  logic [7:0] color_r;
  logic [7:0] color_g;
  logic [7:0] color_b;
  logic       valid;
  logic       start_frame_flag;
  logic       end_frame_flag;

  modport master (
    output color_r, color_g, color_b, valid, start_frame_flag, end_frame_flag
  );

  modport slave (
    input color_r, color_g, color_b, valid, start_frame_flag, end_frame_flag
  );

endinterface

// File: rtl/frame_pattern_gen_lut.sv
// frame_pattern_lut: purely combinational pixel colour mapping.
//   pattern  : PAT_SOLID / PAT_BARS / PAT_GRAD / PAT_CHECK
//   bar_idx  : current colour bar (0..7), maintained incrementally by the caller
//   x        : low byte of the pattern column
//   y_b3     : bit 3 of the line number (the only line bit any pattern uses)
//   solid    : latched solid colour {r,g,b}
//   rgb      : resulting colour {r,g,b}
import frame_pkg::*;

module frame_pattern_lut (
  input  logic [1:0]  pattern,
  input  logic [2:0]  bar_idx,
  input  logic [7:0]  x,
  input  logic        y_b3,
  input  logic [23:0] solid,
  output logic [23:0] rgb
);

  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_SOLID: rgb = solid;
      PAT_BARS:  rgb = bar_color(bar_idx);
      PAT_GRAD:  rgb = {x, x, x};
      PAT_CHECK: rgb = (x[3] ^ y_b3) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

endmodule

// File: rtl/frame_pattern_gen.sv
// frame_pattern_gen: synthetic raster frame source (solid, colour bars,
// gradient, checker) with programmable active size and blanking.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_enable            : run request, sampled in IDLE and at the end of VBLANK
//   i_pattern           : pattern select, latched at every frame start
//   i_solid_r/g/b       : solid colour, latched at every frame start
//   pix (master)        : registered pixel stream with start/end frame flags
//   o_frame_cnt         : completed frames, wraps
// Optional build macro FRAME_GEN_MOTION_EN: the pattern scrolls horizontally
// by one column per frame (x = (h + offset) mod P_H_ACTIVE).
import frame_pkg::*;

module frame_pattern_gen #(
  parameter int P_H_ACTIVE = 640,
  parameter int P_V_ACTIVE = 480,
  parameter int P_H_BLANK  = 16,
  parameter int P_V_BLANK  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [7:0]  i_solid_r,
  input  logic [7:0]  i_solid_g,
  input  logic [7:0]  i_solid_b,
  frame_pattern_gen_if.master pix,
  output logic [15:0] o_frame_cnt
);

  // h doubles as the blank-cycle index inside a VBLANK line, v as the blank
  // line index during VBLANK, so both are sized for the larger use.
  localparam int H_TOTAL = P_H_ACTIVE + P_H_BLANK;
  localparam int V_MAX   = (P_V_ACTIVE > P_V_BLANK) ? P_V_ACTIVE : P_V_BLANK;
  localparam int HCW     = ($clog2(H_TOTAL + 1) > 12) ? $clog2(H_TOTAL + 1) : 12;
  localparam int VCW     = ($clog2(V_MAX + 1) > 12) ? $clog2(V_MAX + 1) : 12;
  localparam int BAR_W   = P_H_ACTIVE / 8;
  localparam int PW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HCW-1:0] H_ACT_LAST = HCW'(P_H_ACTIVE - 1);
  localparam logic [HCW-1:0] H_BLK_LAST = HCW'(P_H_BLANK - 1);
  localparam logic [HCW-1:0] H_TOT_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_LAST = VCW'(P_V_ACTIVE - 1);
  localparam logic [VCW-1:0] V_BLK_LAST = VCW'(P_V_BLANK - 1);
  localparam logic [11:0]    X_LAST     = 12'(P_H_ACTIVE - 1);
  localparam logic [PW-1:0]  PH_LAST    = PW'(BAR_W - 1);

  frame_state_t   state_q, state_d;
  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic [11:0]    x_q, x_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic [PW-1:0]  bar_ph_q, bar_ph_d;
  logic [1:0]     pat_q;
  logic [23:0]    solid_q;
  logic           latch_inputs;
  logic           line_start;
  logic           frame_done;
  logic           first_pixel;
  logic [11:0]    line_x0;
  logic [2:0]     line_idx0;
  logic [PW-1:0]  line_ph0;
  logic [23:0]    rgb;

  assign frame_done  = (state_q == ST_ACTIVE) && (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);
  assign first_pixel = (state_q == ST_ACTIVE) && (h_q == '0) && (v_q == '0);

`ifdef FRAME_GEN_MOTION_EN
  logic [11:0]   offset_q;
  logic [2:0]    off_idx_q;
  logic [PW-1:0] off_ph_q;

  // Offset and its bar index/phase advance together so every line start can
  // reload the bar tracker without a divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      offset_q  <= '0;
      off_idx_q <= '0;
      off_ph_q  <= '0;
    end else if (frame_done) begin
      offset_q <= (offset_q == X_LAST) ? 12'd0 : offset_q + 12'd1;
      if (off_ph_q == PH_LAST) begin
        off_ph_q  <= '0;
        off_idx_q <= off_idx_q + 3'd1;
      end else begin
        off_ph_q <= off_ph_q + PW'(1);
      end
    end
  end

  assign line_x0   = offset_q;
  assign line_idx0 = off_idx_q;
  assign line_ph0  = off_ph_q;
`else
  assign line_x0   = '0;
  assign line_idx0 = '0;
  assign line_ph0  = '0;
`endif

  // Next-state logic. The bar index/phase track x so that the index equals
  // x / BAR_W; because P_H_ACTIVE is exactly 8 bars wide, wrapping x from the
  // last column to 0 also wraps the 3-bit index from 7 to 0.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    x_d          = x_q;
    bar_idx_d    = bar_idx_q;
    bar_ph_d     = bar_ph_q;
    latch_inputs = 1'b0;
    line_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d      = ST_ACTIVE;
          h_d          = '0;
          v_d          = '0;
          latch_inputs = 1'b1;
          line_start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (h_q == H_ACT_LAST) begin
          state_d = ST_HBLANK;
          h_d     = '0;
        end else begin
          h_d = h_q + HCW'(1);
          x_d = (x_q == X_LAST) ? 12'd0 : x_q + 12'd1;
          if (bar_ph_q == PH_LAST) begin
            bar_ph_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_ph_d = bar_ph_q + PW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (h_q == H_BLK_LAST) begin
          h_d = '0;
          if (v_q == V_ACT_LAST) begin
            state_d = ST_VBLANK;
            v_d     = '0;
          end else begin
            state_d    = ST_ACTIVE;
            v_d        = v_q + VCW'(1);
            line_start = 1'b1;
          end
        end else begin
          h_d = h_q + HCW'(1);
        end
      end
      ST_VBLANK: begin
        if (h_q == H_TOT_LAST) begin
          h_d = '0;
          if (v_q == V_BLK_LAST) begin
            v_d = '0;
            if (i_enable) begin
              state_d      = ST_ACTIVE;
              latch_inputs = 1'b1;
              line_start   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            v_d = v_q + VCW'(1);
          end
        end else begin
          h_d = h_q + HCW'(1);
        end
      end
    endcase

    if (line_start) begin
      x_d       = line_x0;
      bar_idx_d = line_idx0;
      bar_ph_d  = line_ph0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      x_q       <= '0;
      bar_idx_q <= '0;
      bar_ph_q  <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      x_q       <= x_d;
      bar_idx_q <= bar_idx_d;
      bar_ph_q  <= bar_ph_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pat_q   <= PAT_SOLID;
      solid_q <= '0;
    end else if (latch_inputs) begin
      pat_q   <= i_pattern;
      solid_q <= {i_solid_r, i_solid_g, i_solid_b};
    end
  end

  frame_pattern_lut u_lut (
    .pattern (pat_q),
    .bar_idx (bar_idx_q),
    .x       (x_q[7:0]),
    .y_b3    (v_q[3]),
    .solid   (solid_q),
    .rgb     (rgb)
  );

  // Outputs are registered from the current counter state, so the stream
  // lags the FSM by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix.valid            <= 1'b0;
      pix.color_r          <= '0;
      pix.color_g          <= '0;
      pix.color_b          <= '0;
      pix.start_frame_flag <= 1'b0;
      pix.end_frame_flag   <= 1'b0;
      o_frame_cnt          <= '0;
    end else begin
      pix.valid            <= (state_q == ST_ACTIVE);
      {pix.color_r, pix.color_g, pix.color_b} <= (state_q == ST_ACTIVE) ? rgb : 24'h0;
      pix.start_frame_flag <= first_pixel;
      pix.end_frame_flag   <= frame_done;
      if (frame_done) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// tb_frame_pattern_gen: randomized scoreboard bench for frame_pattern_gen.
// The driver pushes every expected pixel of a frame (colour, flags, frame
// count, spacing from the previous pixel) when it programs that frame; an
// independent monitor pops and compares on every valid output.
module tb_frame_pattern_gen;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int B2B_GAP = HB + VB * (H + HB) + 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [1:0]  i_pattern;
  logic [7:0]  i_solid_r, i_solid_g, i_solid_b;
  logic [15:0] o_frame_cnt;

  frame_pattern_gen_if pix ();

  frame_pattern_gen #(
    .P_H_ACTIVE (H),
    .P_V_ACTIVE (V),
    .P_H_BLANK  (HB),
    .P_V_BLANK  (VB)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_pattern   (i_pattern),
    .i_solid_r   (i_solid_r),
    .i_solid_g   (i_solid_g),
    .i_solid_b   (i_solid_b),
    .pix         (pix),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] rgb;
    bit          sf;
    bit          ef;
    logic [15:0] cnt;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int model_frames = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference colour for pattern column x on line y.
  function automatic logic [23:0] ref_pixel(int pat, logic [23:0] solid, int x, int y);
    case (pat)
      0: return solid;
      1: return bar_tab[x / (H / 8)];
      2: return {x[7:0], x[7:0], x[7:0]};
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Program the inputs for the next frame to start and queue its pixels.
  task automatic applyStimulus(int pat, logic [23:0] solid, bit b2b);
    int off;
    exp_t e;
    i_pattern = pat[1:0];
    {i_solid_r, i_solid_g, i_solid_b} = solid;
`ifdef FRAME_GEN_MOTION_EN
    off = model_frames % H;
`else
    off = 0;
`endif
    for (int y = 0; y < V; y++) begin
      for (int h = 0; h < H; h++) begin
        e.rgb = ref_pixel(pat, solid, (h + off) % H, y);
        e.sf  = (h == 0 && y == 0);
        e.ef  = (h == H - 1 && y == V - 1);
        e.cnt = e.ef ? 16'(model_frames + 1) : 16'(model_frames);
        if (h == 0 && y == 0) e.gap = b2b ? B2B_GAP : -1;
        else if (h == 0)      e.gap = HB + 1;
        else                  e.gap = 1;
        sb_q.push_back(e);
      end
    end
    model_frames++;
  endtask

  task automatic waitStart();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge i_clk);
      if (pix.start_frame_flag === 1'b1) got = 1'b1;
    end
    checkOutput("start_seen", 32'(got), 32'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge i_clk);
    checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: compare every valid pixel against the scoreboard, and require
  // all-zero colour and flags whenever nothing valid is presented.
  always @(negedge i_clk) begin
    exp_t e;
    cyc++;
    if (pix.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pixel: got valid pixel %0h expected none at cycle %0d",
                 {pix.color_r, pix.color_g, pix.color_b}, cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("pixel_rgb", 32'({pix.color_r, pix.color_g, pix.color_b}), 32'(e.rgb));
        checkOutput("start_flag", 32'(pix.start_frame_flag), 32'(e.sf));
        checkOutput("end_flag", 32'(pix.end_frame_flag), 32'(e.ef));
        checkOutput("frame_cnt", 32'(o_frame_cnt), 32'(e.cnt));
        if (e.gap > 0) checkOutput("pixel_spacing", 32'(cyc - last_valid_cyc), 32'(e.gap));
      end
      last_valid_cyc = cyc;
    end else begin
      checkOutput("blank_zero", 32'({pix.color_r, pix.color_g, pix.color_b,
                                     pix.start_frame_flag, pix.end_frame_flag}), 32'd0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vcount;
    int pat;
    i_rst = 1'b1;
    i_enable = 1'b0;
    i_pattern = 2'd0;
    i_solid_r = 8'd0;
    i_solid_g = 8'd0;
    i_solid_b = 8'd0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_valid", 32'(pix.valid), 32'd0);
    checkOutput("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Solid (10,20,30) first frame, with first-pixel latency check.
    applyStimulus(0, 24'h0A141E, 1'b0);
    i_enable = 1'b1;
    @(negedge i_clk);
    checkOutput("latency_no_early_pixel", 32'(pix.valid), 32'd0);
    @(negedge i_clk);
    checkOutput("latency_first_pixel", 32'({pix.valid, pix.start_frame_flag}), 32'd3);

    // Bars, gradient, checker, then random frames, all back to back.
    for (int k = 1; k < 8; k++) begin
      pat = (k < 4) ? k : int'($urandom_range(0, 3));
      applyStimulus(pat, 24'($urandom), 1'b1);
      waitStart();
    end

    // Drop enable at line 1, pixel 3: the frame must still complete.
    repeat (H + HB + 3) @(negedge i_clk);
    i_enable = 1'b0;
    waitDrain();
    checkOutput("frame_cnt_after_disable", 32'(o_frame_cnt), 32'd8);
    vcount = 0;
    repeat (200) begin
      @(negedge i_clk);
      if (pix.valid === 1'b1) vcount++;
    end
    checkOutput("idle_valid_count", 32'(vcount), 32'd0);
    checkOutput("idle_frame_cnt", 32'(o_frame_cnt), 32'd8);

    // Reset at line 2, pixel 5 of a running frame.
    applyStimulus(int'($urandom_range(0, 3)), 24'($urandom), 1'b0);
    i_enable = 1'b1;
    waitStart();
    repeat (2 * (H + HB) + 5) @(negedge i_clk);
    i_rst = 1'b1;
    i_enable = 1'b0;
    @(posedge i_clk);
    #1;
    sb_q.delete();
    model_frames = 0;
    @(negedge i_clk);
    checkOutput("rst_outputs_zero", 32'({pix.valid, pix.color_r, pix.color_g, pix.color_b,
                                         pix.start_frame_flag, pix.end_frame_flag}), 32'd0);
    checkOutput("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);

    // Two gradient frames after reset (second frame scrolls when motion is built in).
    applyStimulus(2, 24'($urandom), 1'b0);
    i_enable = 1'b1;
    waitStart();
    applyStimulus(2, 24'($urandom), 1'b1);
    waitStart();
    i_enable = 1'b0;
    waitDrain();
    checkOutput("frame_cnt_final", 32'(o_frame_cnt), 32'd2);
    repeat (150) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
